// File: rtl/lt24_pkg.sv
// Constants and state encoding shared by the LT24 sprite path.
package lt24_pkg;

    localparam int          LCD_W           = 240;
    localparam int          LCD_H           = 320;
    localparam int          ROM_AW          = 13;
    localparam logic [15:0] TRANSPARENT_KEY = 16'hF81F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EVAL,
        ST_WRITE,
        ST_NEXT
    } blit_state_e;

endpackage

// File: rtl/blit_pixel_counter.sv
// Column/row walker for one sprite: clears on request, advances raster order,
// flags the final pixel so the FSM can return to idle.
module blit_pixel_counter #(
    parameter int W  = 20,
    parameter int H  = 20,
    parameter int CW = 5,
    parameter int RW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_end;

    assign col_end = (col_q == CW'(W - 1));
    assign last    = col_end && (row_q == RW'(H - 1));
    assign col     = col_q;
    assign row     = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (adv) begin
            if (col_end) begin
                col_d = '0;
                row_d = last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Walks a sprite ROM and emits each opaque, on-screen pixel as a handshaked
// write; romAddr is derived straight from flops so data lands in EVAL.
module sprite_blitter
    import lt24_pkg::*;
#(
    parameter int          SPRITE_W    = 20,
    parameter int          SPRITE_H    = 20,
    parameter logic [15:0] TRANSPARENT = TRANSPARENT_KEY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              draw,
    input  logic [7:0]        xOrigin,
    input  logic [8:0]        yOrigin,
    input  logic [3:0]        ROMId,
    output logic              ready,
    output logic [ROM_AW-1:0] romAddr,
    input  logic [15:0]       romData,
    output logic              pixelWrite,
    output logic [7:0]        xAddr,
    output logic [8:0]        yAddr,
    output logic [15:0]       pixelData,
    input  logic              pixelReady
);

    localparam int CW   = $clog2(SPRITE_W);
    localparam int RW   = $clog2(SPRITE_H);
    localparam int AREA = SPRITE_W * SPRITE_H;

    blit_state_e state_q, state_d;
    logic [7:0]  x_org_q, x_org_d;
    logic [8:0]  y_org_q, y_org_d;
    logic [3:0]  rom_id_q, rom_id_d;
    logic [7:0]  x_addr_q, x_addr_d;
    logic [8:0]  y_addr_q, y_addr_d;
    logic [15:0] pix_q, pix_d;
    logic        pw_q, pw_d;

    logic          cnt_clr, cnt_adv, last;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [8:0]    x_sum;
    logic [9:0]    y_sum;
    logic          skip;

    blit_pixel_counter #(
        .W (SPRITE_W),
        .H (SPRITE_H),
        .CW(CW),
        .RW(RW)
    ) u_cnt (
        .clock(clock),
        .reset(reset),
        .clr  (cnt_clr),
        .adv  (cnt_adv),
        .col  (col),
        .row  (row),
        .last (last)
    );

    // Modulo-2^13 arithmetic gives the required truncation for free.
    assign romAddr = ROM_AW'(rom_id_q) * ROM_AW'(AREA)
                   + ROM_AW'(row) * ROM_AW'(SPRITE_W) + ROM_AW'(col);

    assign x_sum = {1'b0, x_org_q} + 9'(col);
    assign y_sum = {1'b0, y_org_q} + 10'(row);
    assign skip  = (romData == TRANSPARENT) || (x_sum >= 9'(LCD_W))
                || (y_sum >= 10'(LCD_H));

    assign ready      = (state_q == ST_IDLE);
    assign pixelWrite = pw_q;
    assign xAddr      = x_addr_q;
    assign yAddr      = y_addr_q;
    assign pixelData  = pix_q;

    always_comb begin
        state_d  = state_q;
        x_org_d  = x_org_q;
        y_org_d  = y_org_q;
        rom_id_d = rom_id_q;
        x_addr_d = x_addr_q;
        y_addr_d = y_addr_q;
        pix_d    = pix_q;
        cnt_clr  = 1'b0;
        cnt_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (draw) begin
                    x_org_d  = xOrigin;
                    y_org_d  = yOrigin;
                    rom_id_d = ROMId;
                    cnt_clr  = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_EVAL;
            ST_EVAL: begin
                if (skip) begin
                    state_d = ST_NEXT;
                end else begin
                    x_addr_d = x_sum[7:0];
                    y_addr_d = y_sum[8:0];
                    pix_d    = romData;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (pixelReady) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                cnt_adv = 1'b1;
                state_d = last ? ST_IDLE : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered strobe: high exactly while the FSM sits in WRITE.
        pw_d = (state_d == ST_WRITE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x_org_q  <= '0;
            y_org_q  <= '0;
            rom_id_q <= '0;
            x_addr_q <= '0;
            y_addr_q <= '0;
            pix_q    <= '0;
            pw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_org_q  <= x_org_d;
            y_org_q  <= y_org_d;
            rom_id_q <= rom_id_d;
            x_addr_q <= x_addr_d;
            y_addr_q <= y_addr_d;
            pix_q    <= pix_d;
            pw_q     <= pw_d;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ROM model plus expected-write scoreboard.
module tb_sprite_blitter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        draw = 1'b0;
    logic [7:0]  xOrigin = '0;
    logic [8:0]  yOrigin = '0;
    logic [3:0]  ROMId = '0;
    logic        ready;
    logic [12:0] romAddr;
    logic [15:0] romData = '0;
    logic        pixelWrite;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelReady = 1'b1;

    typedef struct packed {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
    } wr_t;

    logic [15:0] rom_mem [0:8191];
    wr_t         exp_q [$];
    int          errors = 0;
    int          checks = 0;

    sprite_blitter dut (
        .clock     (clock),
        .reset     (reset),
        .draw      (draw),
        .xOrigin   (xOrigin),
        .yOrigin   (yOrigin),
        .ROMId     (ROMId),
        .ready     (ready),
        .romAddr   (romAddr),
        .romData   (romData),
        .pixelWrite(pixelWrite),
        .xAddr     (xAddr),
        .yAddr     (yAddr),
        .pixelData (pixelData),
        .pixelReady(pixelReady)
    );

    always #5 clock = ~clock;

    always @(posedge clock) romData <= rom_mem[romAddr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queues the reference write sequence, then issues the draw strobe.
    task automatic start_draw(input logic [3:0] id, input logic [7:0] xo, input logic [8:0] yo);
        exp_q.delete();
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 20; c++) begin
                int   a;
                int   x;
                int   y;
                logic [15:0] d;
                a = int'(id) * 400 + r * 20 + c;
                x = int'(xo) + c;
                y = int'(yo) + r;
                d = rom_mem[a];
                if (d != 16'hF81F && x < 240 && y < 320)
                    exp_q.push_back('{x: 8'(x), y: 9'(y), d: d});
            end
        end
        @(negedge clock);
        xOrigin = xo;
        yOrigin = yo;
        ROMId   = id;
        draw    = 1'b1;
        @(negedge clock);
        draw = 1'b0;
        chk("first_romAddr", 64'(romAddr), 64'(int'(id) * 400));
        chk("busy_after_draw", 64'(ready), 64'd0);
    endtask

    task automatic run_draw(input int abort_after, input int stall_first, input int bad_x,
                            output int n_wr, output int cyc);
        int   stall;
        int   hold;
        logic first;
        logic [32:0] held;
        wr_t  e;
        n_wr  = 0;
        cyc   = 1;
        stall = stall_first;
        hold  = 0;
        first = 1'b1;
        held  = '0;
        while (cyc < 5000) begin
            if (pixelWrite && stall > 0) begin
                pixelReady = 1'b0;
                stall--;
            end else begin
                pixelReady = 1'b1;
            end
            // A draw pulse in the middle of the stall must be ignored.
            if (stall_first > 0 && stall == 2 && pixelWrite && !pixelReady) begin
                draw = 1'b1; xOrigin = 8'd0; yOrigin = 9'd0; ROMId = 4'd0;
            end else begin
                draw = 1'b0;
            end
            if (pixelWrite) begin
                hold++;
                if (hold == 1) held = {xAddr, yAddr, pixelData};
            end
            if (pixelWrite && pixelReady) begin
                if (first && stall_first > 0) begin
                    chk("stall_hold_cycles", 64'(hold), 64'(stall_first + 1));
                    chk("stall_stable", 64'({xAddr, yAddr, pixelData}), 64'(held));
                end
                first = 1'b0;
                hold  = 0;
                if (exp_q.size() == 0) begin
                    chk("extra_write", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_pix", 64'({xAddr, yAddr, pixelData}), 64'(e));
                end
                chk("bounds", 64'(xAddr <= 8'd239 && yAddr <= 9'd319), 64'd1);
                if (bad_x >= 0) chk("transparent_col", 64'(int'(xAddr) != bad_x), 64'd1);
                n_wr++;
                if (abort_after > 0 && n_wr == abort_after) break;
            end
            if (ready) break;
            @(negedge clock);
            cyc++;
        end
        draw       = 1'b0;
        pixelReady = 1'b1;
        chk("no_timeout", 64'(cyc < 5000), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        chk({tag, "_pixelWrite"}, 64'(pixelWrite), 64'd0);
        chk({tag, "_romAddr"}, 64'(romAddr), 64'd0);
        chk({tag, "_xAddr"}, 64'(xAddr), 64'd0);
        chk({tag, "_yAddr"}, 64'(yAddr), 64'd0);
        chk({tag, "_pixelData"}, 64'(pixelData), 64'd0);
    endtask

    initial begin
        int n;
        int c;
        int w;
        for (int a = 0; a < 8192; a++) begin
            rom_mem[a] = 16'(a) ^ 16'h5A5A;
            if (rom_mem[a] == 16'hF81F) rom_mem[a] = 16'h0000;
        end
        for (int a = 400; a < 800; a++) rom_mem[a] = 16'h07E0;
        for (int r = 0; r < 20; r++) rom_mem[800 + r * 20] = 16'hF81F;
        for (int a = 1200; a < 1600; a++) rom_mem[a] = 16'h001F;

        // Asynchronous reset in the middle of a clock phase.
        #3 reset = 1'b1;
        #1 chk_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        // Full opaque sprite.
        start_draw(4'd1, 8'd100, 9'd20);
        run_draw(0, 0, -1, n, c);
        chk("full_writes", 64'(n), 64'd400);
        chk("full_ready_window", 64'(c >= 1600 && c <= 1602), 64'd1);
        chk("full_queue_empty", 64'(exp_q.size()), 64'd0);

        // Transparent first column.
        start_draw(4'd2, 8'd10, 9'd5);
        run_draw(0, 0, 10, n, c);
        chk("transp_writes", 64'(n), 64'd380);
        chk("transp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Clipped at the bottom-right corner.
        start_draw(4'd3, 8'd230, 9'd310);
        run_draw(0, 0, -1, n, c);
        chk("clip_writes", 64'(n), 64'd100);
        chk("clip_queue_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure on the first write plus an ignored draw.
        start_draw(4'd4, 8'd50, 9'd60);
        run_draw(0, 5, -1, n, c);
        chk("stall_writes", 64'(n), 64'd400);
        chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clock);
        chk("no_queued_draw_ready", 64'(ready), 64'd1);
        chk("no_queued_draw_write", 64'(pixelWrite), 64'd0);

        // Reset mid-draw while a write is pending, then restart.
        start_draw(4'd1, 8'd0, 9'd0);
        run_draw(50, 0, -1, n, c);
        chk("abort_writes", 64'(n), 64'd50);
        w = 0;
        while (!pixelWrite && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("abort_pending_write", 64'(pixelWrite), 64'd1);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("midreset");
        @(negedge clock);
        reset = 1'b0;
        start_draw(4'd5, 8'd7, 9'd9);
        run_draw(0, 0, -1, n, c);
        chk("restart_writes", 64'(n), 64'd400);
        chk("restart_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
